// File: rtl/spraid_wb_arbiter.sv
// spraid_wb_arbiter: round-robin two-master Wishbone arbiter in front of the SPI RAID controller,
// with a watchdog that aborts an owner whose cycle is never answered.
module spraid_wb_arbiter #(
  parameter int TIMEOUT = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic        m0_lock_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic        m0_stall_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic        m1_lock_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        m1_stall_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic        s_lock_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  input  logic        s_stall_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;
  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        abort_who_q, abort_who_d;
  logic [15:0] cnt_q, cnt_d;
  logic        own0, own1, resp, owner_cyc, owner_lock, expire, pick1;
  assign own0       = state_q == OWN0;
  assign own1       = state_q == OWN1;
  assign resp       = s_ack_i | s_err_i;
  assign owner_cyc  = own0 ? m0_cyc_i : m1_cyc_i;
  assign owner_lock = own0 ? m0_lock_i : m1_lock_i;
  assign expire     = (own0 | own1) & owner_cyc & ~resp & (cnt_q == 16'(TIMEOUT - 1));
  // last_grant_q set means m1 was granted last, so m0 wins the next tie
  assign pick1      = m1_cyc_i & (~m0_cyc_i | ~last_grant_q);
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    abort_who_d  = abort_who_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (m0_cyc_i | m1_cyc_i) begin
        last_grant_d = pick1;
        state_d      = pick1 ? OWN1 : OWN0;
        cnt_d        = '0;
      end
      OWN0, OWN1: begin
        cnt_d       = resp ? '0 : owner_cyc ? cnt_q + 16'd1 : cnt_q;
        abort_who_d = expire ? own1 : abort_who_q;
        state_d     = expire ? ABORT : (~owner_cyc & ~owner_lock) ? IDLE : state_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      abort_who_q  <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      abort_who_q  <= abort_who_d;
      cnt_q        <= cnt_d;
    end
  end
  assign grant_o    = {own1, own0};
  assign timeout_o  = state_q == ABORT;
  assign s_cyc_o    = own0 ? m0_cyc_i  : own1 & m1_cyc_i;
  assign s_stb_o    = own0 ? m0_stb_i  : own1 & m1_stb_i;
  assign s_we_o     = own0 ? m0_we_i   : own1 & m1_we_i;
  assign s_lock_o   = own0 ? m0_lock_i : own1 & m1_lock_i;
  assign s_adr_o    = own0 ? m0_adr_i  : own1 ? m1_adr_i : '0;
  assign s_dat_o    = own0 ? m0_dat_i  : own1 ? m1_dat_i : '0;
  assign s_sel_o    = own0 ? m0_sel_i  : own1 ? m1_sel_i : '0;
  assign m0_dat_o   = own0 ? s_dat_i : '0;
  assign m0_ack_o   = own0 & s_ack_i;
  assign m0_err_o   = (own0 & s_err_i) | (timeout_o & ~abort_who_q);
  assign m0_rty_o   = own0 & s_rty_i;
  assign m0_stall_o = ~own0 | s_stall_i;
  assign m1_dat_o   = own1 ? s_dat_i : '0;
  assign m1_ack_o   = own1 & s_ack_i;
  assign m1_err_o   = (own1 & s_err_i) | (timeout_o & abort_who_q);
  assign m1_rty_o   = own1 & s_rty_i;
  assign m1_stall_o = ~own1 | s_stall_i;
endmodule

// File: tb/tb_spraid_wb_arbiter.sv
// tb_spraid_wb_arbiter: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural ownership model.
module tb_spraid_wb_arbiter;
  localparam int TO = 8;
  logic        clk = 0, rst = 1;
  logic        cyc [2], stb [2], we [2], lock [2];
  logic [31:0] adr [2], dat [2];
  logic [3:0]  sel [2];
  logic [31:0] mdat [2];
  logic        mack [2], merr [2], mrty [2], mstall [2];
  logic        s_cyc, s_stb, s_we, s_lock;
  logic [31:0] s_adr, s_dat_out, s_dat;
  logic [3:0]  s_sel;
  logic        s_ack, s_err, s_rty, s_stall;
  logic [1:0]  grant;
  logic        tmo;
  int          pass_n = 0, tot_n = 0;
  always #5 clk = ~clk;
  spraid_wb_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_cyc_i(cyc[0]), .m0_stb_i(stb[0]), .m0_we_i(we[0]), .m0_lock_i(lock[0]),
    .m0_adr_i(adr[0]), .m0_dat_i(dat[0]), .m0_sel_i(sel[0]),
    .m0_dat_o(mdat[0]), .m0_ack_o(mack[0]), .m0_err_o(merr[0]), .m0_rty_o(mrty[0]), .m0_stall_o(mstall[0]),
    .m1_cyc_i(cyc[1]), .m1_stb_i(stb[1]), .m1_we_i(we[1]), .m1_lock_i(lock[1]),
    .m1_adr_i(adr[1]), .m1_dat_i(dat[1]), .m1_sel_i(sel[1]),
    .m1_dat_o(mdat[1]), .m1_ack_o(mack[1]), .m1_err_o(merr[1]), .m1_rty_o(mrty[1]), .m1_stall_o(mstall[1]),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_lock_o(s_lock),
    .s_adr_o(s_adr), .s_dat_o(s_dat_out), .s_sel_o(s_sel),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .s_stall_i(s_stall),
    .grant_o(grant), .timeout_o(tmo)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
  endtask
  task automatic step(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); endtask
  task automatic idle_all();
    for (int n = 0; n < 2; n++) begin
      cyc[n] = 0; stb[n] = 0; we[n] = 0; lock[n] = 0; adr[n] = 0; dat[n] = 0; sel[n] = 0;
    end
    s_dat = 0; s_ack = 0; s_err = 0; s_rty = 0; s_stall = 0;
  endtask
  task automatic reset_pulse();
    rst = 1; step(); look(); step(); rst = 0;
  endtask
  // Ownership model: st 0=nobody, 1=m0, 2=m1, 3=abort cycle; silent counts unanswered owned cycles
  int st = 0, ab = 0, silent = 0;
  bit last_m1 = 1;
  logic [146:0] got, exp;
  assign got = {grant, tmo, s_cyc, s_stb, s_we, s_lock, s_adr, s_dat_out, s_sel,
                mdat[0], mack[0], merr[0], mrty[0], mstall[0],
                mdat[1], mack[1], merr[1], mrty[1], mstall[1]};
  always @(negedge clk) begin
    int o, w;
    logic [71:0] sv;
    logic [35:0] mv [2];
    if (rst) begin st = 0; last_m1 = 1; silent = 0; end
    o = st == 1 ? 0 : st == 2 ? 1 : -1;
    sv = '0;
    if (o >= 0) sv = {cyc[o], stb[o], we[o], lock[o], adr[o], dat[o], sel[o]};
    for (int n = 0; n < 2; n++)
      mv[n] = {(o == n) ? s_dat : 32'h0, (o == n) & s_ack, ((o == n) & s_err) | (st == 3 && ab == n),
               (o == n) & s_rty, (o != n) | s_stall};
    exp = {o == 0 ? 2'b01 : o == 1 ? 2'b10 : 2'b00, st == 3, sv, mv[0], mv[1]};
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL model got=%h want=%h t=%0t", got, exp, $time);
    if (!rst) begin
      if (st == 0) begin
        if (cyc[0] | cyc[1]) begin
          w = (cyc[0] & cyc[1]) ? (last_m1 ? 0 : 1) : (cyc[1] ? 1 : 0);
          last_m1 = (w == 1); st = w + 1; silent = 0;
        end
      end else if (st == 3) st = 0;
      else begin
        if (s_ack | s_err) silent = 0;
        else if (cyc[o]) begin
          if (silent == TO - 1) begin st = 3; ab = o; end
          else silent++;
        end
        if (st != 3 && !cyc[o] && !lock[o]) st = 0;
      end
    end
  end
  initial begin
    idle_all();
    step(); step(); look();
    chk("rst_grant", grant, 0); chk("rst_scyc", s_cyc, 0); chk("rst_tmo", tmo, 0);
    chk("rst_stall0", mstall[0], 1); chk("rst_dat0", mdat[0], 0);
    step(); rst = 0;
    // single-master read acked three cycles after grant
    step(); cyc[0] = 1; stb[0] = 1; adr[0] = 32'h30000400; sel[0] = 4'hf;
    look(); chk("rd_latency", grant, 0);
    step(); look(); chk("rd_grant", grant, 2'b01); chk("rd_adr", s_adr, 32'h30000400); chk("rd_stall1", mstall[1], 1);
    step(); step(); s_ack = 1; s_dat = 32'h1;
    look(); chk("rd_ack", mack[0], 1); chk("rd_dat", mdat[0], 32'h1); chk("rd_stall1b", mstall[1], 1);
    step(); s_ack = 0; cyc[0] = 0; stb[0] = 0;
    look(); chk("rd_hold", grant, 2'b01);
    step(); look(); chk("rd_rel", grant, 0);
    // round-robin tie
    reset_pulse();
    cyc[0] = 1; cyc[1] = 1; stb[0] = 1; stb[1] = 1;
    step(); look(); chk("tie_m0", grant, 2'b01);
    step(); cyc[0] = 0;
    step(); cyc[0] = 1; look(); chk("tie_idle", grant, 0);
    step(); look(); chk("tie_m1", grant, 2'b10);
    idle_all(); step(); step();
    // lock held across writes
    cyc[1] = 1; stb[1] = 1; we[1] = 1; lock[1] = 1; adr[1] = 32'h30000010;
    step(); s_ack = 1; look(); chk("lk_grant", grant, 2'b10);
    step(); s_ack = 0; cyc[1] = 0; stb[1] = 0; cyc[0] = 1; stb[0] = 1;
    for (int i = 0; i < 3; i++) begin step(); look(); chk("lk_hold", grant, 2'b10); end
    cyc[1] = 1; stb[1] = 1; s_ack = 1;
    step(); s_ack = 0; cyc[1] = 0; stb[1] = 0; lock[1] = 0;
    look(); chk("lk_hold2", grant, 2'b10);
    step(); look(); chk("lk_idle", grant, 0);
    step(); look(); chk("lk_m0", grant, 2'b01);
    idle_all(); step(); step();
    // watchdog abort with m1 pending
    cyc[0] = 1; stb[0] = 1; we[0] = 1;
    step(); cyc[1] = 1; stb[1] = 1;
    for (int i = 0; i < TO; i++) begin look(); chk("wd_own", grant, 2'b01); step(); end
    look(); chk("wd_tmo", tmo, 1); chk("wd_err", merr[0], 1); chk("wd_grant", grant, 0); chk("wd_scyc", s_cyc, 0);
    step(); look(); chk("wd_idle", grant, 0); chk("wd_tmo_off", tmo, 0);
    step(); look(); chk("wd_m1", grant, 2'b10);
    idle_all(); step(); step();
    // ack on the limit cycle beats the watchdog
    cyc[0] = 1; stb[0] = 1;
    for (int i = 0; i < TO; i++) step();
    s_ack = 1; look(); chk("lim_ack", mack[0], 1); chk("lim_tmo", tmo, 0);
    step(); s_ack = 0; look(); chk("lim_tmo2", tmo, 0); chk("lim_grant", grant, 2'b01);
    idle_all(); step(); step();
    // async reset during a stalled m1 transfer
    cyc[1] = 1; stb[1] = 1; s_stall = 1;
    step(); look(); chk("ar_grant", grant, 2'b10);
    #2 rst = 1; s_ack = 1; #1;
    chk("ar_scyc", s_cyc, 0); chk("ar_grant0", grant, 0); chk("ar_ack", mack[1], 0);
    step(); look(); step(); rst = 0; s_ack = 0; s_stall = 0; cyc[0] = 1; stb[0] = 1;
    step(); look(); chk("ar_tie", grant, 2'b01);
    idle_all(); step(); step();
    // randomized traffic, chatty then mostly silent slave
    for (int i = 0; i < 4000; i++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        cyc[n]  = ($urandom_range(0, 3) != 0) ? cyc[n] : ~cyc[n];
        stb[n]  = cyc[n] & $urandom_range(0, 1);
        we[n]   = 1'($urandom_range(0, 1));
        lock[n] = $urandom_range(0, 7) == 0;
        adr[n]  = $urandom; dat[n] = $urandom; sel[n] = 4'($urandom);
      end
      s_ack   = (i < 2000) ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0;
      s_err   = $urandom_range(0, 15) == 0;
      s_rty   = $urandom_range(0, 7) == 0;
      s_stall = 1'($urandom_range(0, 1));
      s_dat   = $urandom;
    end
    step(); look();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
